// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- memory BIST controller: FSM states,
// March element encoding and the per-element operation table.
package mbist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2,
    DONE_ST = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } elem_t;

  localparam int ERR_CNT_W = 16;

  // March C-: E0 w0 | E1 up r0,w1 | E2 up r1,w0 | E3 dn r0,w1 | E4 dn r1,w0 | E5 r0

  // Address direction: only E3 and E4 walk downwards.
  function automatic logic elem_down(input elem_t e);
    return (e == E3) || (e == E4);
  endfunction

  // Element contains a read operation.
  function automatic logic elem_rd(input elem_t e);
    return e != E0;
  endfunction

  // Element contains a write operation.
  function automatic logic elem_wr(input elem_t e);
    return e != E5;
  endfunction

  // Read expects the inverted background ("1").
  function automatic logic elem_rd_inv(input elem_t e);
    return (e == E2) || (e == E4);
  endfunction

  // Write stores the inverted background ("1").
  function automatic logic elem_wr_inv(input elem_t e);
    return (e == E1) || (e == E3);
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for the March sequencer. Each element starts at
// its own first address (0 when ascending, N-1 when descending); 'last'
// flags the final address of the current direction.
module mbist_addr_gen #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  // Address register: clear on test start, reload at element boundaries, step within an element.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr <= '0;
    end else if (clear) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? TOP_ADDR : '0;
    end else if (step) begin
      addr <= down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign last = down ? (addr == '0) : (addr == TOP_ADDR);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller for a single-port SRAM with 1-cycle read latency.
// All MEM_* pins are registered and present one operation per RUN cycle.
// Read results are compared one cycle after the memory samples the read.
// Optional build macro MBIST_DIAG_EN adds ERR_CNT and FAIL_MAP outputs.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int                ADDR_W = 12,
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] BG_PAT = '0
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 START,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 FAIL,
  output logic [ADDR_W-1:0]    FAIL_ADDR,
  output logic [2:0]           FAIL_ELEM,
  output logic [DATA_W-1:0]    FAIL_BITS,
`ifdef MBIST_DIAG_EN
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic [DATA_W-1:0]    FAIL_MAP,
`endif
  output logic                 MEM_CEN,
  output logic                 MEM_WEN,
  output logic [ADDR_W-1:0]    MEM_A,
  output logic [DATA_W-1:0]    MEM_D,
  output logic                 MEM_OEN,
  input  logic [DATA_W-1:0]    MEM_Q
);

  // The (elem, phase, MEM_A) registers describe the operation currently on
  // the memory pins. phase 0 = read, phase 1 = write.
  state_t state, state_nxt;
  elem_t  elem, elem_nxt, elem_inc;
  logic   phase, phase_nxt;
  logic   issue_nxt, wr_nxt, busy_nxt;
  logic   start_run, op_last_at_addr, addr_last;
  logic   gen_step, gen_load;

  // Compare pipeline registers
  logic              rd_vld;
  logic [DATA_W-1:0] exp_d;
  logic [ADDR_W-1:0] tag_addr;
  elem_t             tag_elem;
  logic              miscmp;
  logic [DATA_W-1:0] diff;

  assign start_run       = START && ((state == IDLE) || (state == DONE_ST));
  assign op_last_at_addr = (elem_rd(elem) && elem_wr(elem)) ? phase : 1'b1;
  assign elem_inc        = (elem == E5) ? E5 : elem_t'(elem + 3'd1);
  assign gen_step        = (state == RUN) && op_last_at_addr && !addr_last;
  assign gen_load        = (state == RUN) && op_last_at_addr && addr_last && (elem != E5);

  mbist_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (CLK),
    .rstn      (RSTN),
    .clear     (start_run),
    .load      (gen_load),
    .load_down (elem_down(elem_inc)),
    .step      (gen_step),
    .down      (elem_down(elem)),
    .addr      (MEM_A),
    .last      (addr_last)
  );

  // Next-state and next-operation decode.
  always_comb begin
    state_nxt = state;
    elem_nxt  = elem;
    phase_nxt = phase;
    issue_nxt = 1'b0;
    unique case (state)
      IDLE, DONE_ST: begin
        if (START) begin
          state_nxt = RUN;
          elem_nxt  = E0;
          phase_nxt = 1'b1;
          issue_nxt = 1'b1;
        end
      end
      RUN: begin
        if (!op_last_at_addr) begin
          phase_nxt = 1'b1;
          issue_nxt = 1'b1;
        end else if (!addr_last) begin
          phase_nxt = !elem_rd(elem);
          issue_nxt = 1'b1;
        end else if (elem == E5) begin
          state_nxt = DRAIN;
        end else begin
          elem_nxt  = elem_inc;
          phase_nxt = !elem_rd(elem_inc);
          issue_nxt = 1'b1;
        end
      end
      DRAIN: begin
        state_nxt = DONE_ST;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign wr_nxt   = issue_nxt && phase_nxt;
  assign busy_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operation registers and registered memory/status pins.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      elem    <= E0;
      phase   <= 1'b0;
      MEM_CEN <= 1'b1;
      MEM_WEN <= 1'b1;
      MEM_D   <= '0;
      MEM_OEN <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      elem    <= elem_nxt;
      phase   <= phase_nxt;
      MEM_CEN <= !issue_nxt;
      MEM_WEN <= !wr_nxt;
      if (wr_nxt) begin
        MEM_D <= elem_wr_inv(elem_nxt) ? ~BG_PAT : BG_PAT;
      end
      MEM_OEN <= !busy_nxt;
      BUSY    <= busy_nxt;
      DONE    <= (state_nxt == DONE_ST);
    end
  end

  assign diff   = MEM_Q ^ exp_d;
  assign miscmp = rd_vld && (diff != '0);

  // Read tag pipeline and first-failure capture with sticky FAIL.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rd_vld    <= 1'b0;
      exp_d     <= '0;
      tag_addr  <= '0;
      tag_elem  <= E0;
      FAIL      <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_ELEM <= '0;
      FAIL_BITS <= '0;
`ifdef MBIST_DIAG_EN
      ERR_CNT   <= '0;
      FAIL_MAP  <= '0;
`endif
    end else if (start_run) begin
      rd_vld    <= 1'b0;
      FAIL      <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_ELEM <= '0;
      FAIL_BITS <= '0;
`ifdef MBIST_DIAG_EN
      ERR_CNT   <= '0;
      FAIL_MAP  <= '0;
`endif
    end else begin
      rd_vld   <= (state == RUN) && !MEM_CEN && MEM_WEN;
      exp_d    <= elem_rd_inv(elem) ? ~BG_PAT : BG_PAT;
      tag_addr <= MEM_A;
      tag_elem <= elem;
      if (miscmp) begin
        FAIL <= 1'b1;
        if (!FAIL) begin
          FAIL_ADDR <= tag_addr;
          FAIL_ELEM <= tag_elem;
          FAIL_BITS <= diff;
        end
`ifdef MBIST_DIAG_EN
        if (ERR_CNT != '1) begin
          ERR_CNT <= ERR_CNT + 1'b1;
        end
        FAIL_MAP <= FAIL_MAP | diff;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: a small instance (ADDR_W=3) for protocol and
// fault-table runs, and a full-size instance (ADDR_W=12) for the real-length
// run, the mid-run reset and the 0xE66 stuck-at-0 case.
module tb_mbist_march_ctrl;

  localparam int SW  = 3;
  localparam int SN  = 8;
  localparam int BW  = 12;
  localparam int BN  = 4096;
  localparam int DW  = 32;
  localparam int OPW = 1 + SW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [OPW-1:0] exp_q[$];

  // Small instance signals
  logic          rstn_s, start_s, busy_s, done_s, fail_s;
  logic [SW-1:0] fail_addr_s;
  logic [2:0]    fail_elem_s;
  logic [DW-1:0] fail_bits_s;
  logic          cen_s, wen_s, oen_s;
  logic [SW-1:0] a_s;
  logic [DW-1:0] d_s, q_s;
`ifdef MBIST_DIAG_EN
  logic [15:0]   err_cnt_s;
  logic [DW-1:0] fail_map_s;
`endif

  // Full-size instance signals
  logic          rstn_b, start_b, busy_b, done_b, fail_b;
  logic [BW-1:0] fail_addr_b;
  logic [2:0]    fail_elem_b;
  logic [DW-1:0] fail_bits_b;
  logic          cen_b, wen_b, oen_b;
  logic [BW-1:0] a_b;
  logic [DW-1:0] d_b, q_b;
`ifdef MBIST_DIAG_EN
  logic [15:0]   err_cnt_b;
  logic [DW-1:0] fail_map_b;
`endif

  mbist_march_ctrl #(.ADDR_W(SW), .DATA_W(DW)) dut_s (
    .CLK(clk), .RSTN(rstn_s), .START(start_s), .BUSY(busy_s), .DONE(done_s),
    .FAIL(fail_s), .FAIL_ADDR(fail_addr_s), .FAIL_ELEM(fail_elem_s), .FAIL_BITS(fail_bits_s),
`ifdef MBIST_DIAG_EN
    .ERR_CNT(err_cnt_s), .FAIL_MAP(fail_map_s),
`endif
    .MEM_CEN(cen_s), .MEM_WEN(wen_s), .MEM_A(a_s), .MEM_D(d_s), .MEM_OEN(oen_s), .MEM_Q(q_s)
  );

  mbist_march_ctrl #(.ADDR_W(BW), .DATA_W(DW)) dut_b (
    .CLK(clk), .RSTN(rstn_b), .START(start_b), .BUSY(busy_b), .DONE(done_b),
    .FAIL(fail_b), .FAIL_ADDR(fail_addr_b), .FAIL_ELEM(fail_elem_b), .FAIL_BITS(fail_bits_b),
`ifdef MBIST_DIAG_EN
    .ERR_CNT(err_cnt_b), .FAIL_MAP(fail_map_b),
`endif
    .MEM_CEN(cen_b), .MEM_WEN(wen_b), .MEM_A(a_b), .MEM_D(d_b), .MEM_OEN(oen_b), .MEM_Q(q_b)
  );

  // Memory models with one injectable stuck-at bit, applied on read.
  logic [DW-1:0] mem_s [SN];
  logic [DW-1:0] mem_b [BN];
  logic          fault_en_s, fault_sa1_s;
  logic [SW-1:0] fault_addr_s;
  int            fault_bit_s;
  localparam logic [BW-1:0] FAULT_ADDR_B = 12'hE66;
  localparam logic [DW-1:0] FAULT_MASK_B = 32'h0800_0000;

  function automatic logic [DW-1:0] apply_fault(input logic [DW-1:0] v, input logic hit,
                                                input int b, input logic sa1);
    logic [DW-1:0] m;
    m = 32'h1 << b;
    if (!hit) return v;
    return sa1 ? (v | m) : (v & ~m);
  endfunction

  always @(posedge clk) begin
    if (!cen_s) begin
      if (!wen_s) mem_s[a_s] <= d_s;
      else q_s <= apply_fault(mem_s[a_s], fault_en_s && (a_s == fault_addr_s), fault_bit_s, fault_sa1_s);
    end
  end

  always @(posedge clk) begin
    if (!cen_b) begin
      if (!wen_b) mem_b[a_b] <= d_b;
      else q_b <= (a_b == FAULT_ADDR_B) ? (mem_b[a_b] & ~FAULT_MASK_B) : mem_b[a_b];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected MEM_* op sequence of March C- on SN words, background 0.
  task automatic push_op(input logic wr, input int a, input logic one);
    logic [SW-1:0] av;
    logic [DW-1:0] dv;
    av = a[SW-1:0];
    dv = (wr && one) ? {DW{1'b1}} : '0;
    exp_q.push_back({!wr, av, dv});
  endtask

  task automatic push_ops();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < SN; i++) begin
        int a;
        a = (e == 3 || e == 4) ? SN - 1 - i : i;
        case (e)
          0: push_op(1'b1, a, 1'b0);
          1: begin push_op(1'b0, a, 1'b0); push_op(1'b1, a, 1'b1); end
          2: begin push_op(1'b0, a, 1'b0); push_op(1'b1, a, 1'b0); end
          3: begin push_op(1'b0, a, 1'b0); push_op(1'b1, a, 1'b1); end
          4: begin push_op(1'b0, a, 1'b0); push_op(1'b1, a, 1'b0); end
          default: push_op(1'b0, a, 1'b0);
        endcase
      end
    end
  endtask

  typedef struct {
    logic          en;
    logic [SW-1:0] addr;
    int            bit_i;
    logic          sa1;
    logic          fail;
    logic [SW-1:0] f_addr;
    logic [2:0]    f_elem;
    logic [DW-1:0] f_bits;
    int            cnt;
  } vec_t;

  vec_t vecs[6];

  // One full small run: op scoreboard, START pokes in RUN and DRAIN, result checks.
  task automatic run_small(input vec_t v, input int poke);
    int            cyc;
    logic [DW-1:0] dm;
    logic [OPW-1:0] act, exp;
    fault_en_s   = v.en;
    fault_addr_s = v.addr;
    fault_bit_s  = v.bit_i;
    fault_sa1_s  = v.sa1;
    push_ops();
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    check("start_busy", busy_s, 1);
    check("start_done", done_s, 0);
    check("start_fail", fail_s, 0);
    check("start_fail_bits", fail_bits_s, 0);
    cyc = 0;
    while (busy_s === 1'b1 && cyc < 200) begin
      start_s = (cyc == poke) || (cyc == SN * 10);
      check("oen_busy", oen_s, 0);
      if (cyc < SN * 10) check("cen_run", cen_s, 0);
      if (cen_s === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("extra_op", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          dm  = wen_s ? '0 : d_s;
          act = {wen_s, a_s, dm};
          check("mem_op", act, exp);
        end
      end
      cyc++;
      @(negedge clk);
    end
    start_s = 1'b0;
    check("busy_len", cyc, SN * 10 + 1);
    check("ops_left", exp_q.size(), 0);
    exp_q.delete();
    check("end_done", done_s, 1);
    check("end_cen", cen_s, 1);
    check("end_wen", wen_s, 1);
    check("end_oen", oen_s, 1);
    check("fail", fail_s, v.fail);
    check("fail_addr", fail_addr_s, v.f_addr);
    check("fail_elem", fail_elem_s, v.f_elem);
    check("fail_bits", fail_bits_s, v.f_bits);
`ifdef MBIST_DIAG_EN
    check("err_cnt", err_cnt_s, v.cnt);
    check("fail_map", fail_map_s, v.f_bits);
`endif
  endtask

  initial begin
    int cyc;
    rstn_s = 1'b0; rstn_b = 1'b0; start_s = 1'b0; start_b = 1'b0;
    fault_en_s = 1'b0; fault_sa1_s = 1'b0; fault_addr_s = '0; fault_bit_s = 0;
    for (int i = 0; i < SN; i++) mem_s[i] = '0;
    for (int i = 0; i < BN; i++) mem_b[i] = '0;
    q_s = '0; q_b = '0;

    //          en    addr  bit sa1   fail  f_addr f_elem f_bits          cnt
    vecs[0] = '{1'b0, 3'd0, 0,  1'b0, 1'b0, 3'd0, 3'd0, 32'h0000_0000, 0};
    vecs[1] = '{1'b1, 3'd6, 27, 1'b0, 1'b1, 3'd6, 3'd2, 32'h0800_0000, 2};
    vecs[2] = '{1'b1, 3'd3, 0,  1'b1, 1'b1, 3'd3, 3'd1, 32'h0000_0001, 3};
    vecs[3] = '{1'b1, 3'd0, 31, 1'b0, 1'b1, 3'd0, 3'd2, 32'h8000_0000, 2};
    vecs[4] = '{1'b1, 3'd7, 5,  1'b1, 1'b1, 3'd7, 3'd1, 32'h0000_0020, 3};
    vecs[5] = '{1'b0, 3'd0, 0,  1'b0, 1'b0, 3'd0, 3'd0, 32'h0000_0000, 0};

    repeat (3) @(negedge clk);
    rstn_s = 1'b1; rstn_b = 1'b1;
    @(negedge clk);
    check("rst_busy", busy_s, 0);
    check("rst_done", done_s, 0);
    check("rst_fail", fail_s, 0);
    check("rst_fail_addr", fail_addr_s, 0);
    check("rst_fail_elem", fail_elem_s, 0);
    check("rst_fail_bits", fail_bits_s, 0);
    check("rst_cen", cen_s, 1);
    check("rst_wen", wen_s, 1);
    check("rst_a", a_s, 0);
    check("rst_d", d_s, 0);
    check("rst_oen", oen_s, 1);
    check("rst_b_busy", busy_b, 0);
    check("rst_b_cen", cen_b, 1);

    for (int i = 0; i < 6; i++) run_small(vecs[i], $urandom_range(1, SN * 10 - 1));

    // Full-size: reset at cycle 100 of a run aborts it immediately.
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    repeat (100) @(negedge clk);
    check("b_busy_c100", busy_b, 1);
    rstn_b = 1'b0;
    @(negedge clk); rstn_b = 1'b1;
    check("abort_busy", busy_b, 0);
    check("abort_done", done_b, 0);
    check("abort_fail", fail_b, 0);
    check("abort_fail_addr", fail_addr_b, 0);
    check("abort_fail_elem", fail_elem_b, 0);
    check("abort_fail_bits", fail_bits_b, 0);
    check("abort_cen", cen_b, 1);
    check("abort_wen", wen_b, 1);
    check("abort_a", a_b, 0);
    check("abort_d", d_b, 0);
    check("abort_oen", oen_b, 1);

    // Full-size run with sa0 on bit 27 at 0xE66.
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    cyc = 0;
    while (busy_b === 1'b1 && cyc < 41100) begin
      cyc++;
      @(negedge clk);
    end
    check("b_busy_len", cyc, 40961);
    check("b_done", done_b, 1);
    check("b_fail", fail_b, 1);
    check("b_fail_addr", fail_addr_b, 12'hE66);
    check("b_fail_elem", fail_elem_b, 2);
    check("b_fail_bits", fail_bits_b, 32'h0800_0000);
    check("b_cen", cen_b, 1);
`ifdef MBIST_DIAG_EN
    check("b_err_cnt", err_cnt_b, 2);
    check("b_fail_map", fail_map_b, 32'h0800_0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- Memory BIST controller that sequences one RA1SHD-class single-port SRAM (4096x32, active-low CEN/WEN/OEN, 1-cycle read latency) through a March C- test.
- Compares read data against expected values and reports pass/fail with first-failure diagnostics.
- Sits between the MBIST top and the memory instance (or its fault-injected wrapper); it owns all memory control pins while BUSY.

Parameters:
- ADDR_W, 12, memory address width; test covers 0 .. 2^ADDR_W-1
- DATA_W, 32, memory word width
- BG_PAT, all-zeros, data background; "0" = BG_PAT, "1" = ~BG_PAT

Ports:
- CLK  in  1  clock
- RSTN  in  1  synchronous active-low reset
- START  in  1  1-cycle pulse; begins the test from IDLE or DONE_ST
- BUSY  out  1  test in progress
- DONE  out  1  test complete; held until the next START
- FAIL  out  1  sticky: at least one miscompare
- FAIL_ADDR  out  ADDR_W  address of the first miscompare
- FAIL_ELEM  out  3  March element (0-5) of the first miscompare
- FAIL_BITS  out  DATA_W  XOR of Q and expected data at the first miscompare
- MEM_CEN  out  1  memory chip enable, active-low
- MEM_WEN  out  1  memory write enable, active-low
- MEM_A  out  ADDR_W  memory address
- MEM_D  out  DATA_W  memory write data
- MEM_OEN  out  1  output enable; tied 0 while BUSY, 1 otherwise
- MEM_Q  in  DATA_W  memory read data, valid the cycle after the read edge

Behaviour:
- Reset (RSTN=0 at CLK edge):
  - BUSY=0, DONE=0, FAIL=0.
  - FAIL_ADDR, FAIL_ELEM and FAIL_BITS = 0.
  - MEM_CEN=1, MEM_WEN=1, MEM_A=0, MEM_D=0, MEM_OEN=1.
  - State IDLE.
  - Reset mid-test aborts immediately; the memory sees CEN=1 from the next edge.
- March C- elements:
  - E0 ⇕(w0)
  - E1 ⇑(r0,w1)
  - E2 ⇑(r1,w0)
  - E3 ⇓(r0,w1)
  - E4 ⇓(r1,w0)
  - E5 ⇕(r0)
  - E0 and E5 run ascending.
- One memory operation per cycle with no idle cycles between operations or elements. With N=2^ADDR_W, the run phase is 10N cycles (40960 for N=4096).
- FSM states: IDLE → RUN on START. RUN → DRAIN after the last E5 read issues. DRAIN → DONE_ST after 1 cycle (final compare). DONE_ST → RUN on START.
- Entering RUN clears FAIL and all diagnostics and sets BUSY=1 on the same edge. START while in RUN or DRAIN is ignored.
- Address counter: up-counts in E0-E2 and E5, down-counts in E3-E4.
  - Wraps from N-1 to 0 (ascending) or from 0 to N-1 (descending) at each element boundary.
  - Elements E1-E4 use a phase bit: read phase, then write phase, same address.
- Outputs are registered. MEM_* change on the CLK edge and are sampled by the memory at the next edge.
- Compare pipeline:
  - Registered read-valid, expected data and (address, element) tag.
  - The compare happens in the cycle MEM_Q is valid: one cycle after the memory samples the read.
  - A miscompare with FAIL=0 captures the tag and the XOR, and sets FAIL. Later miscompares leave the diagnostics unchanged; FAIL stays sticky.
- On DRAIN exit: BUSY=0, DONE=1, MEM_CEN=1, MEM_WEN=1.
- No run-time abort input; RSTN is the only way to stop a test.

Optional Feature:
- Macro MBIST_DIAG_EN.
- Defined:
  - Adds output ERR_CNT (16 bits): saturating count of miscompared reads, cleared on START.
  - Adds output FAIL_MAP (DATA_W bits): OR of all miscompare XORs for the run.
  - The test always completes.
- Undefined:
  - Ports and logic are absent.
  - Only first-fail capture and the sticky FAIL remain.

Decomposition:
- Package mbist_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, DONE_ST).
  - March element encoding E0..E5.
  - Per-element constants: direction, op list, read expected value, write value.
- Sub-module mbist_addr_gen holds the up/down address counter with wrap and last-address flag. The FSM and compare logic stay in the top.

Test Plan:
- Fault-free RA1SHD, ADDR_W=12, START pulse → BUSY high for exactly 40961 cycles; DONE=1, FAIL=0; FAIL_ADDR, FAIL_ELEM, FAIL_BITS = 0.
- Fault-injected memory (sa0, bit 27, address 0xE66) → DONE=1, FAIL=1, FAIL_ADDR=0xE66, FAIL_ELEM=2, FAIL_BITS=0x0800_0000. With MBIST_DIAG_EN: ERR_CNT=2 (E2, E4 reads), FAIL_MAP=0x0800_0000.
- Protocol checker on MEM_* pins, ADDR_W=3 → exact op sequence, 80 cycles:
  - E0 writes to addresses 0..7.
  - E3 issues r0,w1 at address 7 first, down to 0.
  - MEM_CEN=0 throughout RUN.
- RSTN=0 held one edge at cycle 100 of a run → next cycle BUSY=0, MEM_CEN=1, all outputs at reset values. A new START then runs the full length again.
- START pulses during RUN and DRAIN → ignored (run length unchanged). START in DONE_ST → DONE drops, FAIL and diagnostics clear, a new run begins.
